// File: rtl/note_controller.sv
// Converts MIDI note events into an NCO phase increment with optional portamento glide.
// Note-on: acceptance edge plus oct+3 edges (divide, lookup, apply); not ready outside IDLE, no queuing.
module note_controller #(
   parameter int F_CLK_HZ    = 50_000_000,
   parameter int GLIDE_SHIFT = 6
) (
   input  logic        master_clk,
   input  logic        rst,
   input  logic        note_valid,
   output logic        note_ready,
   input  logic        note_on,
   input  logic [6:0]  note_num,
   input  logic        glide_en,
   input  logic        glide_tick,
   output logic [31:0] accumulator_increment_value,
   output logic        nco_mute,
   output logic [6:0]  current_note
);

   typedef enum logic [1:0] {IDLE, DIVIDE, LOOKUP, APPLY} state_t;

   // Top-octave increments for semitones 0..11 (notes 120..131), computed once at elaboration.
   function automatic logic [31:0] table_entry(input int s);
      real r;
      r = 4294967296.0 * 440.0 * (2.0 ** (real'(s + 51) / 12.0)) / real'(F_CLK_HZ);
      return 32'($rtoi(r + 0.5));
   endfunction

   logic [31:0] table_w [16];
   for (genvar g = 0; g < 16; g++) begin : g_table
      localparam logic [31:0] ENTRY = (g < 12) ? table_entry(g) : 32'd0;
      assign table_w[g] = ENTRY;
   end

   state_t      state_q, state_d;
   logic [6:0]  rem_q, rem_d;
   logic [3:0]  oct_q, oct_d;
   logic [6:0]  note_q, note_d;
   logic [31:0] target_q, target_d;
   logic [31:0] inc_q, inc_d;
   logic        mute_q, mute_d;
   logic [6:0]  cur_q, cur_d;

   logic        accept;
   logic        tgt_above;
   logic [31:0] diff;
   logic [31:0] step;

   always_comb begin
      note_ready = (state_q == IDLE) && !rst;
      accept     = note_valid && note_ready;
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      oct_d    = oct_q;
      note_d   = note_q;
      target_d = target_q;
      inc_d    = inc_q;
      mute_d   = mute_q;
      cur_d    = cur_q;

      tgt_above = target_q > inc_q;
      diff      = tgt_above ? (target_q - inc_q) : (inc_q - target_q);
      step      = diff >> GLIDE_SHIFT;
      if (step == 32'd0) begin
         step = 32'd1;
      end

      // step never exceeds diff, so the glide cannot overshoot the target
      if (glide_tick && glide_en && (state_q != APPLY) && (inc_q != target_q)) begin
         inc_d = tgt_above ? (inc_q + step) : (inc_q - step);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (note_on) begin
                  state_d = DIVIDE;
                  rem_d   = note_num;
                  oct_d   = 4'd0;
                  note_d  = note_num;
               end else if (note_num == cur_q) begin
                  mute_d = 1'b1;
               end
            end
         end
         DIVIDE: begin
            if (rem_q >= 7'd12) begin
               rem_d = rem_q - 7'd12;
               oct_d = oct_q + 4'd1;
            end else begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            target_d = table_w[rem_q[3:0]] >> (4'd10 - oct_q);
            state_d  = APPLY;
         end
         APPLY: begin
            cur_d  = note_q;
            mute_d = 1'b0;
            // a silent NCO has nothing to glide from, so it always jumps
            if (!glide_en || mute_q) begin
               inc_d = target_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge master_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rem_q    <= 7'd0;
         oct_q    <= 4'd0;
         note_q   <= 7'd0;
         target_q <= 32'd0;
         inc_q    <= 32'd0;
         mute_q   <= 1'b1;
         cur_q    <= 7'd0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         oct_q    <= oct_d;
         note_q   <= note_d;
         target_q <= target_d;
         inc_q    <= inc_d;
         mute_q   <= mute_d;
         cur_q    <= cur_d;
      end
   end

   assign accumulator_increment_value = inc_q;
   assign nco_mute                    = mute_q;
   assign current_note                = cur_q;

endmodule

// File: tb/tb_note_controller.sv
// Scoreboard bench for note_controller: per-cycle expectations from an event-level reference model.
module tb_note_controller;

   localparam int GLIDE = 6;

   logic        master_clk = 1'b0;
   logic        rst, note_valid, note_on, glide_en, glide_tick;
   logic [6:0]  note_num;
   logic        note_ready, nco_mute;
   logic [31:0] accumulator_increment_value;
   logic [6:0]  current_note;

   always #5 master_clk = ~master_clk;

   note_controller #(.F_CLK_HZ(50_000_000), .GLIDE_SHIFT(GLIDE)) dut (
      .master_clk                  (master_clk),
      .rst                         (rst),
      .note_valid                  (note_valid),
      .note_ready                  (note_ready),
      .note_on                     (note_on),
      .note_num                    (note_num),
      .glide_en                    (glide_en),
      .glide_tick                  (glide_tick),
      .accumulator_increment_value (accumulator_increment_value),
      .nco_mute                    (nco_mute),
      .current_note                (current_note)
   );

   typedef struct packed {
      logic [31:0] inc;
      logic        mute;
      logic [6:0]  cur;
      logic        rdy;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: a pending note completes at a known edge number.
   longint      m_cycle = 0;
   bit          m_busy = 1'b0;
   int          m_note = 0;
   longint      m_lookup_at = 0, m_done_at = 0;
   logic [31:0] m_inc = 32'd0, m_tgt = 32'd0;
   bit          m_mute = 1'b1;
   int          m_cur = 0;

   function automatic logic [31:0] ref_table(input int s);
      real r;
      r = 4294967296.0 * 440.0 * (2.0 ** (real'(s + 51) / 12.0)) / 50000000.0;
      return 32'($rtoi(r + 0.5));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit v, input bit on, input int num,
                       input bit en, input bit tk);
      bit          apply, accept;
      logic [31:0] d, s;
      @(negedge master_clk);
      rst = r; note_valid = v; note_on = on; note_num = 7'(num);
      glide_en = en; glide_tick = tk;
      m_cycle++;
      if (r) begin
         m_busy = 1'b0; m_inc = 32'd0; m_tgt = 32'd0; m_mute = 1'b1; m_cur = 0;
      end else begin
         apply  = m_busy && (m_cycle == m_done_at);
         accept = v && !m_busy;
         if (tk && en && !apply && (m_inc != m_tgt)) begin
            d = (m_tgt > m_inc) ? m_tgt - m_inc : m_inc - m_tgt;
            s = d >> GLIDE;
            if (s == 32'd0) s = 32'd1;
            m_inc = (m_tgt > m_inc) ? m_inc + s : m_inc - s;
         end
         if (m_busy && (m_cycle == m_lookup_at))
            m_tgt = ref_table(m_note % 12) >> (10 - m_note / 12);
         if (apply) begin
            m_cur = m_note;
            if (!en || m_mute) m_inc = m_tgt;
            m_mute = 1'b0;
            m_busy = 1'b0;
         end
         if (accept) begin
            if (on) begin
               m_busy      = 1'b1;
               m_note      = num;
               m_lookup_at = m_cycle + num / 12 + 2;
               m_done_at   = m_cycle + num / 12 + 3;
            end else if (num == m_cur) begin
               m_mute = 1'b1;
            end
         end
      end
      sb_q.push_back('{m_inc, m_mute, 7'(m_cur), !m_busy && !r});
   endtask

   task automatic idle(input int n, input bit en, input bit tk);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, en, tk);
   endtask

   task automatic sample();
      @(posedge master_clk);
      #2;
   endtask

   // Monitor: compares DUT outputs against the next scoreboard entry after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge master_clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_inc", accumulator_increment_value, e.inc);
            check("sb_mute", {31'd0, nco_mute}, {31'd0, e.mute});
            check("sb_cur", {25'd0, current_note}, {25'd0, e.cur});
            check("sb_ready", {31'd0, note_ready}, {31'd0, e.rdy});
         end
      end
   end

   initial begin
      bit en_r;
      int num;
      rst = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_num = 7'd0;
      glide_en = 1'b0; glide_tick = 1'b0;

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      sample();
      check("rst_ready", {31'd0, note_ready}, 32'd0);
      check("rst_inc", accumulator_increment_value, 32'd0);
      check("rst_mute", {31'd0, nco_mute}, 32'd1);
      idle(1, 0, 0);
      sample();
      check("ready_after_rst", {31'd0, note_ready}, 32'd1);

      // note 69, no glide
      step(0, 1, 1, 69, 0, 1);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, 0, 0, 1);
         if (i == 7) begin
            sample();
            check("n69_busy_t7", {31'd0, note_ready}, 32'd0);
         end
      end
      sample();
      check("n69_inc", accumulator_increment_value, 32'd37795);
      check("n69_mute", {31'd0, nco_mute}, 32'd0);
      check("n69_cur", {25'd0, current_note}, 32'd69);

      step(0, 1, 0, 70, 0, 0);
      sample();
      check("off70_mute", {31'd0, nco_mute}, 32'd0);
      step(0, 1, 0, 69, 0, 0);
      sample();
      check("off69_mute", {31'd0, nco_mute}, 32'd1);
      check("off69_inc", accumulator_increment_value, 32'd37795);

      // glide from 69 to 81
      step(0, 1, 1, 69, 0, 0);
      idle(9, 0, 0);
      step(0, 1, 1, 81, 1, 0);
      idle(10, 1, 0);
      sample();
      check("n81_nojump", accumulator_increment_value, 32'd37795);
      check("n81_cur", {25'd0, current_note}, 32'd81);
      step(0, 0, 0, 0, 1, 1);
      sample();
      check("glide_step1", accumulator_increment_value, 32'd38385);
      step(0, 0, 0, 0, 1, 1);
      sample();
      check("glide_step2", accumulator_increment_value, 32'd38966);
      idle(2000, 1, 1);
      sample();
      check("glide_settle", accumulator_increment_value, 32'd75591);

      // note 0 jumps when glide disabled
      step(0, 1, 1, 0, 0, 1);
      idle(3, 0, 1);
      sample();
      check("n0_inc", accumulator_increment_value, 32'd702);

      // reset mid-divide
      step(0, 1, 1, 127, 0, 0);
      idle(2, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      sample();
      check("abort_inc", accumulator_increment_value, 32'd0);
      check("abort_mute", {31'd0, nco_mute}, 32'd1);
      check("abort_cur", {25'd0, current_note}, 32'd0);

      // note 127, then a valid pulse while in APPLY of note 60
      step(0, 1, 1, 127, 0, 0);
      idle(13, 0, 0);
      step(0, 1, 1, 60, 0, 0);
      idle(7, 0, 0);
      step(0, 1, 1, 100, 0, 0);
      sample();
      check("apply_ignore_cur", {25'd0, current_note}, 32'd60);
      check("apply_ignore_rdy", {31'd0, note_ready}, 32'd1);

      // randomized phase
      en_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(63) == 0) en_r = ~en_r;
         if ($urandom_range(299) == 0) begin
            step(1, 0, 0, 0, en_r, 0);
         end else if ($urandom_range(3) == 0) begin
            if ($urandom_range(9) < 6) begin
               step(0, 1, 1, int'($urandom_range(127)), en_r, $urandom_range(1) == 1);
            end else begin
               num = ($urandom_range(1) == 1) ? m_cur : int'($urandom_range(127));
               step(0, 1, 0, num, en_r, $urandom_range(1) == 1);
            end
         end else begin
            step(0, 0, 0, 0, en_r, $urandom_range(3) != 0);
         end
      end

      sample();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
